fir: RTL and testbench

//  Single-channel FIR filter on IEEE-754 single-precision samples.

---
 rtl/fir_if.sv | 30 +++
 rtl/fir.sv | 254 +++++++++++++++++++++++++
 tb/tb_fir.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_if.sv
// Sample/result handshake bundle for the fir block.
//   in    : float32 sample from the source, valid the cycle after next was seen
//   stop  : source exhausted, sampled by the filter when it loads a sample
//   next  : one-cycle request for a new sample (filter -> source)
//   out   : float32 result, held until the next result
//   ready : one-cycle strobe marking a new result on out
// master = sample source / result sink side, slave = filter side.
interface fir_if;
    logic [31:0] in;
    logic        stop;
    logic        next;
    logic [31:0] out;
    logic        ready;

    modport master (
        output in,
        output stop,
        input  next,
        input  out,
        input  ready
    );

    modport slave (
        input  in,
        input  stop,
        output next,
        output out,
        output ready
    );
endinterface

// File: rtl/fir.sv
// Single-channel float32 FIR filter with one shared multiplier and adder.
// Requests a sample, shifts it into the history, then accumulates
// c[k]*x[k] for k = 0..TAPS-1 one term per cycle and strobes the result.
// Ports:
//   clk   : clock, all state on posedge
//   rst   : asynchronous active-low reset
//   bus   : fir_if.slave (in, stop, next, out, ready)
// Parameters:
//   TAPS  : number of coefficients / history depth (>= 1)
//   COEF  : packed float32 coefficients, COEF[32*k +: 32] = c[k]
// Build option:
//   FIR_SAT_EN : finite-operand overflow clamps to +/-max finite instead of Inf
module fir #(
    parameter int unsigned            TAPS = 4,
    parameter logic [32*TAPS-1:0]     COEF = {TAPS{32'h3E80_0000}}
) (
    input  logic clk,
    input  logic rst,
    fir_if.slave bus
);

    localparam int unsigned KW       = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG  = 31'h7F80_0000;
`ifdef FIR_SAT_EN
    localparam logic [30:0] OVF_MAG  = 31'h7F7F_FFFF;
`else
    localparam logic [30:0] OVF_MAG  = 31'h7F80_0000;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        LOAD = 3'd2,
        MAC  = 3'd3,
        OUT  = 3'd4,
        DONE = 3'd5
    } state_t;

    // Float32 multiply, RNE, subnormals flushed to signed zero.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic              sa, sb, s;
        logic [7:0]        ea, eb;
        logic [22:0]       fa, fb;
        logic              nan_a, nan_b, inf_a, inf_b, zro_a, zro_b;
        logic [47:0]       p;
        logic [23:0]       m;
        logic              g, st, up;
        logic [24:0]       mr;
        logic [22:0]       frac;
        logic signed [9:0] e;
        logic [31:0]       r;
        {sa, ea, fa} = a;
        {sb, eb, fb} = b;
        s     = sa ^ sb;
        nan_a = (ea == 8'hFF) && (fa != 23'd0);
        nan_b = (eb == 8'hFF) && (fb != 23'd0);
        inf_a = (ea == 8'hFF) && (fa == 23'd0);
        inf_b = (eb == 8'hFF) && (fb == 23'd0);
        zro_a = (ea == 8'h00);
        zro_b = (eb == 8'h00);
        p = 48'({1'b1, fa}) * 48'({1'b1, fb});
        e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        // Product of two [1,2) mantissas lies in [1,4); renormalise on the top bit.
        if (p[47]) begin
            m  = p[47:24];
            g  = p[23];
            st = |p[22:0];
            e  = e + 10'sd1;
        end else begin
            m  = p[46:23];
            g  = p[22];
            st = |p[21:0];
        end
        up = g & (st | m[0]);
        mr = {1'b0, m} + 25'(up);
        if (mr[24]) begin
            e    = e + 10'sd1;
            frac = mr[23:1];
        end else begin
            frac = mr[22:0];
        end
        if (nan_a || nan_b)                      r = QNAN;
        else if ((inf_a && zro_b) || (zro_a && inf_b)) r = QNAN;
        else if (inf_a || inf_b)                 r = {s, INF_MAG};
        else if (zro_a || zro_b)                 r = {s, 31'd0};
        else if (e >= 10'sd255)                  r = {s, OVF_MAG};
        else if (e <= 10'sd0)                    r = {s, 31'd0};
        else                                     r = {s, e[7:0], frac};
        return r;
    endfunction

    // Float32 add, RNE, subnormals flushed to signed zero.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic              sa, sb, sl;
        logic [7:0]        ea, eb, el, es, d;
        logic [22:0]       fa, fb, fl, fs;
        logic              nan_a, nan_b, inf_a, inf_b, zro_a, zro_b;
        logic [26:0]       ext_l, ext_s, sh, lost, norm;
        logic [27:0]       sum;
        logic              up;
        logic [24:0]       mr;
        logic [22:0]       frac;
        logic signed [9:0] e;
        int                lz;
        logic [31:0]       r;
        {sa, ea, fa} = a;
        {sb, eb, fb} = b;
        nan_a = (ea == 8'hFF) && (fa != 23'd0);
        nan_b = (eb == 8'hFF) && (fb != 23'd0);
        inf_a = (ea == 8'hFF) && (fa == 23'd0);
        inf_b = (eb == 8'hFF) && (fb == 23'd0);
        zro_a = (ea == 8'h00);
        zro_b = (eb == 8'h00);
        // Larger magnitude first so the subtraction never goes negative.
        if ({ea, fa} < {eb, fb}) begin
            sl = sb; el = eb; fl = fb; es = ea; fs = fa;
        end else begin
            sl = sa; el = ea; fl = fa; es = eb; fs = fb;
        end
        d     = el - es;
        ext_l = {1'b1, fl, 3'b000};
        ext_s = {1'b1, fs, 3'b000};
        // Align with guard/round bits plus a sticky bit in the LSB.
        if (d >= 8'd27) begin
            sh   = 27'd1;
            lost = 27'd0;
        end else begin
            sh    = ext_s >> d;
            lost  = ext_s & ((27'd1 << d) - 27'd1);
            sh[0] = sh[0] | (|lost);
        end
        if (sa ^ sb) sum = {1'b0, ext_l} - {1'b0, sh};
        else         sum = {1'b0, ext_l} + {1'b0, sh};
        e  = $signed({2'b00, el});
        lz = 0;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 26 - i;
        end
        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            e    = e + 10'sd1;
        end else begin
            norm = sum[26:0] << lz;
            e    = e - $signed(10'(lz));
        end
        up = norm[2] & ((|norm[1:0]) | norm[3]);
        mr = {1'b0, norm[26:3]} + 25'(up);
        if (mr[24]) begin
            e    = e + 10'sd1;
            frac = mr[23:1];
        end else begin
            frac = mr[22:0];
        end
        if (nan_a || nan_b)                   r = QNAN;
        else if (inf_a && inf_b && (sa != sb)) r = QNAN;
        else if (inf_a)                       r = {sa, INF_MAG};
        else if (inf_b)                       r = {sb, INF_MAG};
        else if (zro_a && zro_b)              r = {sa & sb, 31'd0};
        else if (zro_a)                       r = b;
        else if (zro_b)                       r = a;
        else if (sum == 28'd0)                r = 32'd0;
        else if (e >= 10'sd255)               r = {sl, OVF_MAG};
        else if (e <= 10'sd0)                 r = {sl, 31'd0};
        else                                  r = {sl, e[7:0], frac};
        return r;
    endfunction

    state_t          state, state_d;
    logic [KW-1:0]   k, k_d;
    logic [31:0]     acc, acc_d;
    logic [31:0]     out_q, out_d;
    logic            next_q, next_d;
    logic            ready_q, ready_d;
    logic            shift_en;
    logic [31:0]     hist [TAPS];
    logic [31:0]     c_k, prod_c, sum_c;

    // Shared MAC datapath for the current tap.
    always_comb begin
        c_k    = COEF[32*int'(k) +: 32];
        prod_c = fmul(c_k, hist[k]);
        sum_c  = fadd(acc, prod_c);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // Next-state and registered-output logic; next/ready/out follow the state being entered.
    always_comb begin
        state_d  = state;
        k_d      = k;
        acc_d    = acc;
        out_d    = out_q;
        shift_en = 1'b0;
        next_d   = 1'b0;
        ready_d  = 1'b0;
        case (state)
            IDLE: state_d = REQ;
            REQ:  state_d = LOAD;
            LOAD: begin
                if (bus.stop) begin
                    state_d = DONE;
                end else begin
                    shift_en = 1'b1;
                    acc_d    = 32'd0;
                    k_d      = '0;
                    state_d  = MAC;
                end
            end
            MAC: begin
                acc_d = sum_c;
                if (k == KW'(TAPS - 1)) state_d = OUT;
                else                    k_d     = k + KW'(1);
            end
            OUT:     state_d = REQ;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        next_d  = (state_d == REQ);
        ready_d = (state_d == OUT);
        if (state_d == OUT) out_d = acc_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k       <= '0;
            acc     <= 32'd0;
            out_q   <= 32'd0;
            next_q  <= 1'b0;
            ready_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) hist[i] <= 32'd0;
        end else begin
            k       <= k_d;
            acc     <= acc_d;
            out_q   <= out_d;
            next_q  <= next_d;
            ready_q <= ready_d;
            if (shift_en) begin
                for (int i = TAPS - 1; i > 0; i--) hist[i] <= hist[i-1];
                hist[0] <= bus.in;
            end
        end
    end

    assign bus.next  = next_q;
    assign bus.ready = ready_q;
    assign bus.out   = out_q;

endmodule

// File: tb/tb_fir.sv
// Scoreboard bench for fir: three instances with different coefficient sets,
// only the selected one is out of reset at a time.
module tb_fir;

`ifdef FIR_SAT_EN
    localparam logic [31:0] OVF_EXP = 32'h7F7F_FFFF;
`else
    localparam logic [31:0] OVF_EXP = 32'h7F80_0000;
`endif

    logic        clk;
    logic [2:0]  rst_v;
    logic [31:0] in_d;
    logic        stop_d;
    int          sel;

    fir_if f0();
    fir_if f1();
    fir_if f2();

    assign f0.in = in_d;  assign f0.stop = stop_d;
    assign f1.in = in_d;  assign f1.stop = stop_d;
    assign f2.in = in_d;  assign f2.stop = stop_d;

    fir #(.TAPS(4)) u0 (.clk(clk), .rst(rst_v[0]), .bus(f0.slave));
    fir #(.TAPS(4), .COEF(128'h4080_0000_4040_0000_4000_0000_3F80_0000))
        u1 (.clk(clk), .rst(rst_v[1]), .bus(f1.slave));
    fir #(.TAPS(4), .COEF({4{32'h4080_0000}}))
        u2 (.clk(clk), .rst(rst_v[2]), .bus(f2.slave));

    logic        next_s, ready_s;
    logic [31:0] out_s;
    assign next_s  = (sel == 0) ? f0.next  : (sel == 1) ? f1.next  : f2.next;
    assign ready_s = (sel == 0) ? f0.ready : (sel == 1) ? f1.ready : f2.ready;
    assign out_s   = (sel == 0) ? f0.out   : (sel == 1) ? f1.out   : f2.out;

    logic [31:0] samp_q[$];
    logic [31:0] expv_q[$];
    logic [31:0] exp_q[$];
    int          n_chk, n_fail, cyc, last_next, rdy_cnt, n_push;
    logic [31:0] last_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Source: answer each request with the next queued sample, or stop when empty.
    initial begin
        forever begin
            @(negedge clk);
            if (next_s) begin
                @(posedge clk);
                #1;
                if (samp_q.size() != 0) begin
                    in_d = samp_q.pop_front();
                    exp_q.push_back(expv_q.pop_front());
                end else begin
                    stop_d = 1'b1;
                end
            end
        end
    end

    // Sink: compare results and handshake timing.
    initial begin
        forever begin
            @(negedge clk);
            if (next_s || ready_s)
                chk("no_overlap", 32'(next_s & ready_s), 32'd0);
            if (next_s) begin
                if (last_next >= 0) chk("period", 32'(cyc - last_next), 32'd7);
                last_next = cyc;
            end
            if (ready_s) begin
                rdy_cnt++;
                chk("latency", 32'(cyc - last_next), 32'd6);
                if (exp_q.size() == 0) begin
                    chk("extra_ready", 32'd1, 32'd0);
                end else begin
                    last_exp = exp_q.pop_front();
                    chk("out", out_s, last_exp);
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [31:0] x, input logic [31:0] y);
        samp_q.push_back(x);
        expv_q.push_back(y);
        n_push++;
    endtask

    task automatic start_dut(input int s);
        rst_v  = 3'b000;
        sel    = s;
        stop_d = 1'b0;
        in_d   = 32'd0;
        samp_q.delete();
        expv_q.delete();
        exp_q.delete();
        last_next = -1;
        rdy_cnt   = 0;
        n_push    = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_next",  32'(next_s),  32'd0);
        chk("rst_ready", 32'(ready_s), 32'd0);
        chk("rst_out",   out_s,        32'd0);
        rst_v[s] = 1'b1;
    endtask

    task automatic drain();
        int t;
        int q;
        t = 0;
        while ((samp_q.size() != 0 || exp_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", 32'(t >= 3000), 32'd0);
        repeat (10) @(negedge clk);
        q = 0;
        repeat (40) begin
            @(negedge clk);
            if (next_s || ready_s) q++;
        end
        chk("done_quiet",  32'(q),       32'd0);
        chk("done_hold",   out_s,        last_exp);
        chk("ready_count", 32'(rdy_cnt), 32'(n_push));
    endtask

    initial begin
        int t;
        n_chk = 0; n_fail = 0; last_next = -1; rdy_cnt = 0; n_push = 0;
        last_exp = 32'd0; rst_v = 3'b000; sel = 0; in_d = 32'd0; stop_d = 1'b0;

        // Constant 1.0 with 4x0.25 coefficients: ramp up then settle.
        start_dut(0);
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: push(32'h3F80_0000, 32'h3E80_0000);
                1: push(32'h3F80_0000, 32'h3F00_0000);
                2: push(32'h3F80_0000, 32'h3F40_0000);
                default: push(32'h3F80_0000, 32'h3F80_0000);
            endcase
        end
        drain();

        // Signed zero, mixed signs and a subnormal input.
        start_dut(0);
        push(32'h8000_0000, 32'h0000_0000);
        push(32'h3FC0_0000, 32'h3EC0_0000);
        push(32'hC000_0000, 32'hBE00_0000);
        push(32'h4040_0000, 32'h3F20_0000);
        push(32'h0040_0000, 32'h3F20_0000);
        drain();

        // Stop on the fourth request: three results only.
        start_dut(0);
        push(32'h3F80_0000, 32'h3E80_0000);
        push(32'h3F80_0000, 32'h3F00_0000);
        push(32'h3F80_0000, 32'h3F40_0000);
        drain();

        // Impulse response with coefficients 1,2,3,4.
        start_dut(1);
        push(32'h3F80_0000, 32'h3F80_0000);
        push(32'h0000_0000, 32'h4000_0000);
        push(32'h0000_0000, 32'h4040_0000);
        push(32'h0000_0000, 32'h4080_0000);
        push(32'h0000_0000, 32'h0000_0000);
        drain();

        // Rounding ties: 2 + 2*x lands exactly half an ulp; odd rounds up, even stays.
        start_dut(1);
        push(32'h4B80_0001, 32'h4B80_0001);
        push(32'h4000_0000, 32'h4C00_0002);
        drain();
        start_dut(1);
        push(32'h4B80_0000, 32'h4B80_0000);
        push(32'h4000_0000, 32'h4C00_0000);
        drain();

        // Overflow and NaN with coefficients 4.0.
        start_dut(2);
        push(32'h7F7F_FFFF, OVF_EXP);
        push(32'h7FC0_0001, 32'h7FC0_0000);
        drain();

        // Inf propagates; Inf + -Inf is the canonical NaN.
        start_dut(2);
        push(32'h7F80_0000, 32'h7F80_0000);
        push(32'hFF80_0000, 32'h7FC0_0000);
        drain();

        // Reset during MAC aborts the sample and clears history.
        start_dut(0);
        push(32'h4000_0000, 32'h3F00_0000);
        t = 0;
        while (!next_s && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("abort_req_seen", 32'(t >= 50), 32'd0);
        repeat (3) @(negedge clk);
        rst_v[0] = 1'b0;
        samp_q.delete();
        expv_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_ready", 32'(ready_s), 32'd0);
            chk("abort_out",   out_s,        32'd0);
        end
        last_next = -1;
        rdy_cnt   = 0;
        n_push    = 0;
        last_exp  = 32'd0;
        rst_v[0]  = 1'b1;
        push(32'h3F80_0000, 32'h3E80_0000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
